rr_arbiter_4: RTL and testbench



---
 rtl/rr_arbiter_4_pkg.sv | 29 ++
 rtl/rr_arbiter_4_pick.sv | 37 +++
 rtl/rr_arbiter_4.sv | 100 ++++++++++
 tb/tb_rr_arbiter_4.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter_4_pkg                                          |
// | Brief    : Shared constants, state encoding and helpers for the      |
// |            four-input round-robin arbiter.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package rr_arbiter_4_pkg;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Index of the set bit in a one-hot vector; zero for an all-zero vector.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_4_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_pick_4                                                 |
// | Brief    : Combinational rotate-priority picker. Scans req from ptr  |
// |            upward (mod 4); the first set bit wins.                   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_pick_4
    import rr_arbiter_4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // Walk the request lines in rotated order and keep only the first hit.
    always_comb begin
        onehot  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ptr + PTR_W'(i);
            if (!w_found && req[w_idx]) begin
                onehot[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter_4                                              |
// | Brief    : Four-input round-robin arbiter with a registered one-hot  |
// |            grant held until a valid/ready accept.                    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter_4 #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               gnt_ready,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid
);

    import rr_arbiter_4_pkg::*;

    // The picker and pointer arithmetic are built for exactly four lines.
    if (NUM_REQ != 4) begin : g_cfg_error
        $error("rr_arbiter_4: NUM_REQ must be 4");
    end

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [PTR_W-1:0]   w_pick_ptr;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] w_onehot;
    logic               w_any;
    logic               w_accept;

    assign w_accept = (r_state == ST_GRANT) && gnt_ready;

    // On accept the served line drops to lowest priority, and the picker
    // already sees that rotated pointer so a back-to-back grant is possible.
    assign w_pick_ptr = w_accept ? (onehot_to_idx(r_gnt) + PTR_W'(1)) : r_ptr;

    rr_pick_4 u_pick (
        .req    (req),
        .ptr    (w_pick_ptr),
        .onehot (w_onehot),
        .any    (w_any)
    );

    // State, pointer and grant registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Next-state: load a winner from IDLE, hold in GRANT until accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt   = w_onehot;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (gnt_ready) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (w_any) begin
                        w_gnt_nxt = w_onehot;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; valid is the GRANT state itself.
    always_comb begin
        gnt       = r_gnt;
        gnt_valid = (r_state == ST_GRANT);
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_rr_arbiter_4                                           |
// | Brief    : Scoreboard bench for rr_arbiter_4 with a behavioural      |
// |            round-robin reference model.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       gnt_ready;
    logic [3:0] gnt;
    logic       gnt_valid;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [3:0] gnt;
        logic       vld;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: index of the pending grant (-1 = none) and the
    // position that currently has highest priority.
    int m_idx;
    int m_ptr;

    rr_arbiter_4 #(.NUM_REQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_ready (gnt_ready),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Advance the model by one rising edge and record the expected outputs.
    task automatic model_step(input bit r, input logic [3:0] rq, input bit rd);
        exp_t e;
        if (r) begin
            m_idx = -1;
            m_ptr = 0;
        end else if (m_idx >= 0) begin
            if (rd) begin
                m_ptr = (m_idx + 1) % 4;
                m_idx = pick(rq, m_ptr);
            end
        end else begin
            m_idx = pick(rq, m_ptr);
        end
        e.gnt = (m_idx < 0) ? 4'b0000 : 4'(1 << m_idx);
        e.vld = (m_idx >= 0);
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit r, input logic [3:0] rq, input bit rd);
        @(negedge clk);
        #1;
        rst       = r;
        req       = rq;
        gnt_ready = rd;
        model_step(r, rq, rd);
    endtask

    // Monitor: one expectation is consumed per cycle, half a period after the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (gnt !== e.gnt) begin
                n_errors++;
                $display("FAIL gnt at %0t: got %b expected %b", $time, gnt, e.gnt);
            end
            n_checks++;
            if (gnt_valid !== e.vld) begin
                n_errors++;
                $display("FAIL gnt_valid at %0t: got %b expected %b", $time, gnt_valid, e.vld);
            end
            n_checks++;
            if (($countones(gnt) > 1) || ((gnt != 4'b0000) != gnt_valid)) begin
                n_errors++;
                $display("FAIL invariant at %0t: gnt %b gnt_valid %b", $time, gnt, gnt_valid);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        m_idx     = -1;
        m_ptr     = 0;
        rst       = 1'b1;
        req       = 4'b0000;
        gnt_ready = 1'b0;

        // Reset held with all requests, then first grant goes to line 0.
        cycle(1, 4'b1111, 0);
        cycle(1, 4'b1111, 0);
        cycle(0, 4'b1111, 0);
        cycle(1, 4'b0000, 0);

        // Single requester with a consumer always ready.
        repeat (5) cycle(0, 4'b0001, 1);
        cycle(1, 4'b0000, 0);

        // Full rotation.
        repeat (5) cycle(0, 4'b1111, 1);
        cycle(1, 4'b0000, 0);

        // Stall: grant frozen despite req changing, then accept picks 0100.
        cycle(0, 4'b1010, 0);
        cycle(0, 4'b1010, 0);
        cycle(0, 4'b0100, 0);
        cycle(0, 4'b0100, 0);
        cycle(0, 4'b0100, 1);
        cycle(0, 4'b0000, 1);
        cycle(0, 4'b0000, 0);
        cycle(1, 4'b0000, 0);

        // Wrap after serving line 3, then return to idle.
        cycle(0, 4'b1000, 0);
        cycle(0, 4'b1001, 1);
        cycle(0, 4'b0000, 1);
        cycle(0, 4'b0000, 1);
        cycle(1, 4'b0000, 0);

        // Reset while a grant is pending restarts from index 0.
        cycle(0, 4'b0100, 0);
        cycle(0, 4'b0100, 0);
        cycle(1, 4'b0100, 0);
        cycle(0, 4'b1111, 0);
        cycle(0, 4'b1111, 1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 2) != 0));
        end

        repeat (2) @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
